// File: rtl/asc_hex_pkg.sv
// Shared constants and types for the ASCII-hex stream parser.
// Holds the delimiter byte values and the parser state encoding.
package asc_hex_pkg;

    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_POISON,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/asc_hex_stream_to_word_if.sv
// Byte-in / word-out handshake bundle for the ASCII-hex parser.
// The slave modport is the parser; the master modport is its environment.
interface asc_hex_stream_to_word_if #(
    parameter int WORD_NIBBLES = 8
);

    localparam int DW = 4 * WORD_NIBBLES;
    localparam int LW = $clog2(WORD_NIBBLES + 1);

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [LW-1:0] out_len;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_len, out_err, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_len, out_err, out_valid
    );

endinterface

// File: rtl/asc_hex_char_decode.sv
// Combinational ASCII classifier: hex digit value, hex flag, delimiter flag.
// nyb is only meaningful when is_hex is set.
module asc_hex_char_decode
    import asc_hex_pkg::*;
(
    input  logic [7:0] char_code,
    output logic [3:0] nyb,
    output logic       is_hex,
    output logic       is_delim
);

    always_comb begin
        nyb    = 4'h0;
        is_hex = 1'b0;
        if (char_code >= 8'h30 && char_code <= 8'h39) begin
            is_hex = 1'b1;
            nyb    = 4'(char_code - 8'h30);
        end else if (char_code >= 8'h41 && char_code <= 8'h46) begin
            is_hex = 1'b1;
            nyb    = 4'(char_code - 8'h37);
        end else if (char_code >= 8'h61 && char_code <= 8'h66) begin
            is_hex = 1'b1;
            nyb    = 4'(char_code - 8'h57);
        end
    end

    assign is_delim = (char_code == CH_SPACE) || (char_code == CH_TAB) ||
                      (char_code == CH_LF)    || (char_code == CH_CR)  ||
                      (char_code == CH_COMMA);

endmodule

// File: rtl/asc_hex_stream_to_word.sv
// Streaming ASCII-hex parser: assembles hex digits MSB-first into a word,
// emitting on a full word or a delimiter, and flagging malformed tokens.
module asc_hex_stream_to_word
    import asc_hex_pkg::*;
#(
    parameter int WORD_NIBBLES = 8,
    parameter bit STRICT       = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    asc_hex_stream_to_word_if.slave  bus
);

    localparam int DW = 4 * WORD_NIBBLES;
    localparam int LW = $clog2(WORD_NIBBLES + 1);
    localparam logic [LW-1:0] FULL = LW'(WORD_NIBBLES);

    logic [3:0]    nyb;
    logic          is_hex;
    logic          is_delim;

    state_t        state, state_nxt;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_shift;
    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_inc;

    logic [DW-1:0] out_data_q;
    logic [LW-1:0] out_len_q;
    logic          out_err_q;

    logic          take;
    logic          acc_shift_en;
    logic          acc_clr;
    logic          emit;
    logic          emit_err;

    asc_hex_char_decode u_decode (
        .char_code (bus.in_data),
        .nyb       (nyb),
        .is_hex    (is_hex),
        .is_delim  (is_delim)
    );

    // Shift form keeps WORD_NIBBLES=1 legal (no negative part-select).
    assign acc_shift = (acc << 4) | DW'(nyb);
    assign cnt_inc   = cnt + LW'(1);
    assign take      = bus.in_valid && (state != ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        acc_shift_en = 1'b0;
        acc_clr      = 1'b0;
        emit         = 1'b0;
        emit_err     = 1'b0;
        case (state)
            ST_ACCUM: begin
                if (take) begin
                    if (is_hex) begin
                        acc_shift_en = 1'b1;
                        if (cnt_inc == FULL) begin
                            emit      = 1'b1;
                            state_nxt = ST_HOLD;
                        end
                    end else if (is_delim) begin
                        if (cnt != '0) begin
                            emit      = 1'b1;
                            state_nxt = ST_HOLD;
                        end
                    end else if (STRICT) begin
                        state_nxt = ST_POISON;
                    end
                end
            end
            ST_POISON: begin
                if (take && is_delim) begin
                    emit      = 1'b1;
                    emit_err  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    acc_clr   = 1'b1;
                    state_nxt = ST_ACCUM;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    // A completing digit is folded into the emitted word in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            out_data_q <= '0;
            out_len_q  <= '0;
            out_err_q  <= 1'b0;
        end else begin
            if (acc_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (acc_shift_en) begin
                acc <= acc_shift;
                cnt <= cnt_inc;
            end
            if (emit) begin
                out_err_q <= emit_err;
                if (emit_err) begin
                    out_data_q <= '0;
                    out_len_q  <= '0;
                end else if (is_hex) begin
                    out_data_q <= acc_shift;
                    out_len_q  <= cnt_inc;
                end else begin
                    out_data_q <= acc;
                    out_len_q  <= cnt;
                end
            end
        end
    end

    assign bus.in_ready  = (state != ST_HOLD);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_asc_hex_stream_to_word.sv
// Directed bench for asc_hex_stream_to_word: a STRICT=1 and a STRICT=0 instance,
// byte strings driven in, emitted words compared against hand-computed values.
module tb_asc_hex_stream_to_word;

    localparam int WN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [36:0] s_q[$];
    logic [36:0] l_q[$];

    always #5 clk = ~clk;

    asc_hex_stream_to_word_if #(.WORD_NIBBLES(WN)) s_if ();
    asc_hex_stream_to_word_if #(.WORD_NIBBLES(WN)) l_if ();

    asc_hex_stream_to_word #(.WORD_NIBBLES(WN), .STRICT(1'b1)) u_strict (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    asc_hex_stream_to_word #(.WORD_NIBBLES(WN), .STRICT(1'b0)) u_lax (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    // Capture every completed output handshake; out_ready only changes just after posedge.
    always @(negedge clk) begin
        if (!rst && s_if.out_valid && s_if.out_ready)
            s_q.push_back({s_if.out_data, s_if.out_len, s_if.out_err});
        if (!rst && l_if.out_valid && l_if.out_ready)
            l_q.push_back({l_if.out_data, l_if.out_len, l_if.out_err});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input bit lax, input logic [7:0] b);
        int n;
        logic rdy;
        n = 0;
        @(negedge clk);
        if (lax) begin l_if.in_data = b; l_if.in_valid = 1'b1; end
        else     begin s_if.in_data = b; s_if.in_valid = 1'b1; end
        rdy = lax ? l_if.in_ready : s_if.in_ready;
        while (!rdy && n < 64) begin
            @(negedge clk);
            n++;
            rdy = lax ? l_if.in_ready : s_if.in_ready;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h in_ready stayed 0, required 1", b);
        end
        @(posedge clk);
    endtask

    task automatic send_str(input bit lax, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(lax, s[i]);
        #1;
        if (lax) l_if.in_valid = 1'b0;
        else     s_if.in_valid = 1'b0;
    endtask

    task automatic expect_word(input bit lax, input string tag, input logic [31:0] d,
                               input logic [3:0] len, input logic err);
        int n;
        int sz;
        logic [36:0] got;
        n  = 0;
        sz = lax ? l_q.size() : s_q.size();
        while (sz == 0 && n < 100) begin
            @(negedge clk);
            n++;
            sz = lax ? l_q.size() : s_q.size();
        end
        checks++;
        if (sz == 0) begin
            failures++;
            $display("FAIL %s: no word emitted, required data=%h len=%0d err=%0b", tag, d, len, err);
        end else begin
            if (lax) got = l_q.pop_front();
            else     got = s_q.pop_front();
            assert (got === {d, len, err}) else begin
                failures++;
                $error("FAIL %s: got data=%h len=%0d err=%0b, required data=%h len=%0d err=%0b",
                       tag, got[36:5], got[4:1], got[0], d, len, err);
            end
        end
    endtask

    initial begin
        s_if.in_data = 8'h00; s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
        l_if.in_data = 8'h00; l_if.in_valid = 1'b0; l_if.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  64'(s_if.in_ready),  64'd1);
        chk("rst_out_valid", 64'(s_if.out_valid), 64'd0);
        chk("rst_out_data",  64'(s_if.out_data),  64'd0);
        chk("rst_out_len",   64'(s_if.out_len),   64'd0);
        chk("rst_out_err",   64'(s_if.out_err),   64'd0);

        send_str(0, "1a2B\n");
        expect_word(0, "mixed_case", 32'h00001A2B, 4'd4, 1'b0);

        send_str(0, "DEADBEEF12 ");
        expect_word(0, "overflow_full", 32'hDEADBEEF, 4'd8, 1'b0);
        expect_word(0, "overflow_next", 32'h00000012, 4'd2, 1'b0);

        send_str(0, "CAFEF00D\n");
        expect_word(0, "full_then_delim", 32'hCAFEF00D, 4'd8, 1'b0);

        send_str(0, "12G4,7\015");
        expect_word(0, "strict_poison", 32'h00000000, 4'd0, 1'b1);
        expect_word(0, "after_poison",  32'h00000007, 4'd1, 1'b0);

        send_str(0, "0,,\t 8\n");
        expect_word(0, "zero_digit",    32'h00000000, 4'd1, 1'b0);
        expect_word(0, "after_delims",  32'h00000008, 4'd1, 1'b0);

        send_str(1, "12G4 ");
        expect_word(1, "lax_drop", 32'h00000124, 4'd3, 1'b0);

        // Backpressure: word "5" held for five cycles while '6' waits on the input.
        @(posedge clk);
        #1 s_if.out_ready = 1'b0;
        send_byte(0, "5");
        send_byte(0, "\n");
        @(negedge clk);
        s_if.in_data = "6";
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", 64'(s_if.out_valid), 64'd1);
            chk("hold_in_ready",  64'(s_if.in_ready),  64'd0);
            chk("hold_out_data",  64'(s_if.out_data),  64'h5);
            chk("hold_out_len",   64'(s_if.out_len),   64'd1);
            @(negedge clk);
        end
        chk("hold_no_early_pop", 64'(s_q.size()), 64'd0);
        @(posedge clk);
        #1 s_if.out_ready = 1'b1;
        send_byte(0, "6");
        send_str(0, "\n");
        expect_word(0, "held_word",    32'h00000005, 4'd1, 1'b0);
        expect_word(0, "pending_byte", 32'h00000006, 4'd1, 1'b0);

        send_str(0, "AB");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send_str(0, "C\n");
        expect_word(0, "rst_mid_token", 32'h0000000C, 4'd1, 1'b0);

        @(posedge clk);
        #1 s_if.out_ready = 1'b0;
        send_str(0, "9\n");
        @(negedge clk);
        chk("pre_rst_hold_valid", 64'(s_if.out_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; s_if.out_ready = 1'b1; end
        @(negedge clk);
        chk("rst_hold_out_valid", 64'(s_if.out_valid), 64'd0);
        chk("rst_hold_in_ready",  64'(s_if.in_ready),  64'd1);
        chk("rst_hold_out_data",  64'(s_if.out_data),  64'd0);
        chk("rst_hold_out_len",   64'(s_if.out_len),   64'd0);

        repeat (10) @(negedge clk);
        chk("no_extra_strict", 64'(s_q.size()), 64'd0);
        chk("no_extra_lax",    64'(l_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
